handshake_protocol_monitor: RTL and testbench
=============================================

Name: handshake_protocol_monitor

Overview:
- Parametrised, synthesizable ready/valid protocol checker for NUM_CHANNELS independent handshake channels.
- Successor to the fixed three-channel inline-assertion monitor. Adds sticky per-channel error flags for valid-drop, payload-change and stall-timeout, plus saturating transfer counters and first-error channel capture.
- Sits beside the DUT as a passive bound observer. It drives nothing into the DUT.

Parameters:
- NUM_CHANNELS, 3: number of monitored handshake channels, minimum 1.
- DATA_WIDTH, 4: payload width per channel, minimum 1.
- TIMEOUT, 16: consecutive stalled cycles that raise a timeout, minimum 2.
- CNT_WIDTH, 16: width of each transfer counter.
- ID_WIDTH, $clog2(NUM_CHANNELS) with a minimum of 1: width of the channel index.

Ports:
- CLK  in  1  clock; all sampling is on the rising edge.
- ASYNCRESETN  in  1  asynchronous active-low reset.
- enable  in  1  when 0, all state holds.
- clear  in  1  synchronous clear of flags, counters and FSMs.
- valid  in  NUM_CHANNELS  per-channel valid.
- ready  in  NUM_CHANNELS  per-channel ready.
- data  in  NUM_CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- xfer_count  out  NUM_CHANNELS*CNT_WIDTH  per-channel count of completed transfers.
- err_valid_drop  out  NUM_CHANNELS  sticky flag.
- err_data_change  out  NUM_CHANNELS  sticky flag.
- err_timeout  out  NUM_CHANNELS  sticky flag.
- any_error  out  1  OR of all sticky flags.
- first_err_valid  out  1  sticky; set when the first error is captured.
- first_err_chan  out  ID_WIDTH  channel that raised the first error.

Behaviour:
- Reset: ASYNCRESETN low immediately forces the following. Reset may assert mid-stall; no error is raised for the aborted stall.
  - all outputs to 0;
  - all FSMs to IDLE;
  - stall counters and captured payloads to 0.
- Precedence per edge: reset, then clear, then enable=0 (hold), then normal update.
- clear=1: same effect as reset, applied synchronously. An error detected on the same edge is discarded.
- Per-channel FSM, two states, IDLE and WAIT.
  - IDLE, valid&ready: transfer; count += 1; stay IDLE.
  - IDLE, valid&!ready: go WAIT; capture data; stall_cnt = 1.
  - IDLE, !valid: stay IDLE.
  - WAIT, valid&ready: transfer; count += 1; go IDLE; stall_cnt = 0. Data is still compared on this edge.
  - WAIT, !valid: set err_valid_drop; go IDLE; stall_cnt = 0.
  - WAIT, valid&!ready: stay WAIT; stall_cnt += 1, saturating at TIMEOUT.
- Data check: in WAIT with valid high, data != captured sets err_data_change.
  - The captured value is not updated, so each later mismatch re-checks against the original payload.
- Timeout: err_timeout sets on the edge where stall_cnt would reach TIMEOUT, i.e. the TIMEOUT-th consecutive sampled edge with valid&!ready. The FSM stays in WAIT.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Error flags rise one cycle after the offending edge's inputs; they are registered outputs. any_error is the combinational OR of the flag registers.
- first_err_chan:
  - Captured on the first edge where any new error sets while first_err_valid=0.
  - If several channels error on that edge, the lowest index wins.
  - Held until reset or clear.
- Channels are fully independent; there are no cross-channel interactions except the first-error capture.

Decomposition:
- Package handshake_mon_pkg holds:
  - the FSM state typedef, with IDLE=1'b0 and WAIT=1'b1;
  - an error-kind enum: VALID_DROP, DATA_CHANGE, TIMEOUT.
- Sub-module handshake_channel_checker contains:
  - one channel's FSM, captured payload, stall counter and transfer counter;
  - its three flags, plus a one-cycle new_err pulse.
- The top generates NUM_CHANNELS instances and implements the priority encoder for first_err_chan.

Test Plan:
1. Reset, then 5 back-to-back transfers on channel 0 (valid=ready=1 for 5 edges) -> xfer_count[0]=5; no flags; any_error=0.
2. Channel 1: valid=1, ready=0 with data=4'hA for 3 edges, then ready=1 -> 1 transfer, no error. Repeat with data changed to 4'h5 on the second stall edge -> err_data_change[1]=1, first_err_chan=1.
3. Channel 2: valid high with ready low for 2 edges, then valid drops -> err_valid_drop[2]=1 the following cycle, FSM returns to IDLE. A later clean transfer increments the count and leaves the flag sticky.
4. TIMEOUT=16, channel 0 stalled for 16 edges -> err_timeout[0] is 0 after 15 edges and 1 after 16. With simultaneous valid drops on channels 2 and 1 on one edge -> first_err_chan=1.
5. CNT_WIDTH=3, 9 transfers -> count saturates at 7.
6. Pulse clear while errors are set -> all flags and counts read 0 next cycle. ASYNCRESETN asserted mid-stall between edges -> outputs clear immediately, no timeout after release. enable=0 during a stall -> stall_cnt and flags frozen.

Source files
------------

// File: rtl/handshake_mon_pkg.sv
// Shared types for the ready/valid handshake monitor: channel FSM states and error kinds.

package handshake_mon_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } chan_state_e;

  typedef enum logic [1:0] {
    ErrValidDrop  = 2'd0,
    ErrDataChange = 2'd1,
    ErrTimeout    = 2'd2
  } err_kind_e;

  localparam int unsigned NumErrKinds = 3;

endpackage

// File: rtl/handshake_channel_checker.sv
// Protocol checker for a single ready/valid channel: stall tracking, payload stability,
// transfer counting and sticky error flags.

module handshake_channel_checker
  import handshake_mon_pkg::*;
#(
  parameter int unsigned DataWidth = 4,
  parameter int unsigned Timeout   = 16,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [CntWidth-1:0]  xfer_count_o,
  output logic                 err_valid_drop_o,
  output logic                 err_data_change_o,
  output logic                 err_timeout_o,
  output logic                 new_err_o
);

  localparam int unsigned StallWidth = $clog2(Timeout + 1);
  localparam logic [StallWidth-1:0] StallMax  = StallWidth'(Timeout);
  localparam logic [StallWidth-1:0] StallLast = StallWidth'(Timeout - 1);

  chan_state_e             state_q, state_d;
  logic [DataWidth-1:0]    data_q, data_d;
  logic [StallWidth-1:0]   stall_q, stall_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [NumErrKinds-1:0]  err_q, err_d;
  logic [NumErrKinds-1:0]  det;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    stall_d = stall_q;
    cnt_d   = cnt_q;
    det     = '0;

    unique case (state_q)
      StIdle: begin
        if (valid_i && !ready_i) begin
          state_d = StWait;
          data_d  = data_i;
          stall_d = StallWidth'(1);
        end
      end
      StWait: begin
        // Compare against the payload captured when the stall began, not the last one seen.
        if (valid_i && (data_i != data_q)) det[ErrDataChange] = 1'b1;
        if (!valid_i) begin
          det[ErrValidDrop] = 1'b1;
          state_d           = StIdle;
          stall_d           = '0;
        end else if (ready_i) begin
          state_d = StIdle;
          stall_d = '0;
        end else begin
          if (stall_q == StallLast) det[ErrTimeout] = 1'b1;
          if (stall_q != StallMax) stall_d = stall_q + 1'b1;
        end
      end
    endcase

    if (valid_i && ready_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    err_d = err_q | det;
  end

  // Errors found on an edge that is clearing or holding are discarded.
  assign new_err_o = en_i & ~clr_i & (|det);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      data_q  <= '0;
      stall_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else if (clr_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      stall_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else if (en_i) begin
      state_q <= state_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign xfer_count_o      = cnt_q;
  assign err_valid_drop_o  = err_q[ErrValidDrop];
  assign err_data_change_o = err_q[ErrDataChange];
  assign err_timeout_o     = err_q[ErrTimeout];

endmodule

// File: rtl/handshake_protocol_monitor.sv
// Passive multi-channel ready/valid protocol monitor with sticky error flags, saturating
// transfer counters and capture of the first channel to report an error.

module handshake_protocol_monitor
  import handshake_mon_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned ID_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               CLK,
  input  logic                               ASYNCRESETN,
  input  logic                               enable,
  input  logic                               clear,
  input  logic [NUM_CHANNELS-1:0]            valid,
  input  logic [NUM_CHANNELS-1:0]            ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  xfer_count,
  output logic [NUM_CHANNELS-1:0]            err_valid_drop,
  output logic [NUM_CHANNELS-1:0]            err_data_change,
  output logic [NUM_CHANNELS-1:0]            err_timeout,
  output logic                               any_error,
  output logic                               first_err_valid,
  output logic [ID_WIDTH-1:0]                first_err_chan
);

  logic [NUM_CHANNELS-1:0] new_err;
  logic [ID_WIDTH-1:0]     first_sel;
  logic                    fev_q;
  logic [ID_WIDTH-1:0]     fec_q;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    handshake_channel_checker #(
      .DataWidth (DATA_WIDTH),
      .Timeout   (TIMEOUT),
      .CntWidth  (CNT_WIDTH)
    ) u_checker (
      .clk_i             (CLK),
      .rst_ni            (ASYNCRESETN),
      .en_i              (enable),
      .clr_i             (clear),
      .valid_i           (valid[i]),
      .ready_i           (ready[i]),
      .data_i            (data[i*DATA_WIDTH +: DATA_WIDTH]),
      .xfer_count_o      (xfer_count[i*CNT_WIDTH +: CNT_WIDTH]),
      .err_valid_drop_o  (err_valid_drop[i]),
      .err_data_change_o (err_data_change[i]),
      .err_timeout_o     (err_timeout[i]),
      .new_err_o         (new_err[i])
    );
  end

  // Scan downwards so the lowest erroring channel index wins.
  always_comb begin
    first_sel = '0;
    for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
      if (new_err[i]) first_sel = ID_WIDTH'(i);
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      fev_q <= 1'b0;
      fec_q <= '0;
    end else if (clear) begin
      fev_q <= 1'b0;
      fec_q <= '0;
    end else if (enable && !fev_q && (|new_err)) begin
      fev_q <= 1'b1;
      fec_q <= first_sel;
    end
  end

  assign any_error       = (|err_valid_drop) | (|err_data_change) | (|err_timeout);
  assign first_err_valid = fev_q;
  assign first_err_chan  = fec_q;

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Scoreboard bench: a driver pushes reference-model predictions, a monitor pops and compares.

module tb_handshake_protocol_monitor;

  localparam int NC = 3;
  localparam int DW = 4;
  localparam int TO = 16;
  localparam int CW = 3;
  localparam int IW = 2;

  logic              CLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic [NC-1:0]     valid = '0;
  logic [NC-1:0]     ready = '0;
  logic [NC*DW-1:0]  data = '0;
  logic [NC*CW-1:0]  xfer_count;
  logic [NC-1:0]     err_valid_drop, err_data_change, err_timeout;
  logic              any_error, first_err_valid;
  logic [IW-1:0]     first_err_chan;

  handshake_protocol_monitor #(
    .NUM_CHANNELS (NC),
    .DATA_WIDTH   (DW),
    .TIMEOUT      (TO),
    .CNT_WIDTH    (CW)
  ) dut (
    .CLK             (CLK),
    .ASYNCRESETN     (rst_n),
    .enable          (en),
    .clear           (clr),
    .valid           (valid),
    .ready           (ready),
    .data            (data),
    .xfer_count      (xfer_count),
    .err_valid_drop  (err_valid_drop),
    .err_data_change (err_data_change),
    .err_timeout     (err_timeout),
    .any_error       (any_error),
    .first_err_valid (first_err_valid),
    .first_err_chan  (first_err_chan)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NC*CW-1:0] cnt;
    logic [NC-1:0]    vd;
    logic [NC-1:0]    dc;
    logic [NC-1:0]    to;
    logic             any;
    logic             fev;
    logic [IW-1:0]    fec;
  } obs_t;

  obs_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: a channel is either "offering" (pending) or not, with the stall length
  // tracked as an unbounded integer.
  bit m_pend[NC];
  int m_held[NC];
  int m_stall[NC];
  int m_cnt[NC];
  bit m_vd[NC], m_dc[NC], m_to[NC];
  bit m_fev;
  int m_fec;

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_pend[i] = 0; m_held[i] = 0; m_stall[i] = 0; m_cnt[i] = 0;
      m_vd[i] = 0; m_dc[i] = 0; m_to[i] = 0;
    end
    m_fev = 0;
    m_fec = 0;
  endfunction

  function automatic void model_step(logic [NC-1:0] v, logic [NC-1:0] r,
                                     logic [NC*DW-1:0] d, logic e, logic c);
    bit hit[NC];
    int dv;
    int cmax;
    cmax = (1 << CW) - 1;
    if (c) begin
      model_reset();
      return;
    end
    if (!e) return;
    for (int i = 0; i < NC; i++) begin
      hit[i] = 0;
      dv = int'(d[i*DW +: DW]);
      if (v[i] && r[i] && m_cnt[i] < cmax) m_cnt[i]++;
      if (!m_pend[i]) begin
        if (v[i] && !r[i]) begin
          m_pend[i] = 1; m_held[i] = dv; m_stall[i] = 1;
        end
      end else begin
        if (v[i] && dv != m_held[i]) begin m_dc[i] = 1; hit[i] = 1; end
        if (!v[i]) begin
          m_vd[i] = 1; hit[i] = 1; m_pend[i] = 0; m_stall[i] = 0;
        end else if (r[i]) begin
          m_pend[i] = 0; m_stall[i] = 0;
        end else begin
          m_stall[i]++;
          if (m_stall[i] == TO) begin m_to[i] = 1; hit[i] = 1; end
        end
      end
    end
    if (!m_fev) begin
      for (int i = 0; i < NC; i++) begin
        if (hit[i] && !m_fev) begin m_fev = 1; m_fec = i; end
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.any = 0;
    for (int i = 0; i < NC; i++) begin
      o.cnt[i*CW +: CW] = CW'(m_cnt[i]);
      o.vd[i] = m_vd[i];
      o.dc[i] = m_dc[i];
      o.to[i] = m_to[i];
      o.any = o.any | m_vd[i] | m_dc[i] | m_to[i];
    end
    o.fev = m_fev;
    o.fec = IW'(m_fec);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.cnt = xfer_count;
    o.vd  = err_valid_drop;
    o.dc  = err_data_change;
    o.to  = err_timeout;
    o.any = any_error;
    o.fev = first_err_valid;
    o.fec = first_err_chan;
    return o;
  endfunction

  task automatic cycle(input logic [NC-1:0] v, input logic [NC-1:0] r,
                       input logic [NC*DW-1:0] d, input logic e, input logic c);
    @(negedge CLK);
    valid = v; ready = r; data = d; en = e; clr = c;
    model_step(v, r, d, e, c);
    sb_q.push_back(model_obs());
  endtask

  task automatic rand_cycle(input int rdy_div);
    logic [NC-1:0]    v, r;
    logic [NC*DW-1:0] d;
    for (int i = 0; i < NC; i++) begin
      if (m_pend[i]) begin
        v[i] = ($urandom_range(0, 24) != 0);
        d[i*DW +: DW] = ($urandom_range(0, 15) == 0) ? DW'($urandom) : DW'(m_held[i]);
      end else begin
        v[i] = ($urandom_range(0, 2) != 0);
        d[i*DW +: DW] = DW'($urandom);
      end
      r[i] = ($urandom_range(0, rdy_div) == 0);
    end
    cycle(v, r, d, ($urandom_range(0, 15) != 0), ($urandom_range(0, 79) == 0));
  endtask

  task automatic check_now(input string name);
    obs_t got, exp;
    got = dut_obs();
    exp = model_obs();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Monitor: compare one prediction just after each rising edge.
  initial begin
    obs_t got, exp;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        got = dut_obs();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL scoreboard t=%0t got cnt=%h vd=%b dc=%b to=%b any=%b fev=%b fec=%0d expected cnt=%h vd=%b dc=%b to=%b any=%b fev=%b fec=%0d",
                   $time, got.cnt, got.vd, got.dc, got.to, got.any, got.fev, got.fec,
                   exp.cnt, exp.vd, exp.dc, exp.to, exp.any, exp.fev, exp.fec);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #3;
    check_now("reset_state");
    @(negedge CLK);
    rst_n = 1'b1;

    // Back-to-back transfers on channel 0.
    for (int k = 0; k < 5; k++) cycle(3'b001, 3'b001, '0, 1'b1, 1'b0);

    // Channel 1 clean stall then accept, then a stall with a payload change.
    for (int k = 0; k < 3; k++) cycle(3'b010, 3'b000, 12'h0A0, 1'b1, 1'b0);
    cycle(3'b010, 3'b010, 12'h0A0, 1'b1, 1'b0);
    cycle(3'b010, 3'b000, 12'h0A0, 1'b1, 1'b0);
    cycle(3'b010, 3'b000, 12'h050, 1'b1, 1'b0);
    cycle(3'b010, 3'b010, 12'h0A0, 1'b1, 1'b0);

    // Channel 2 valid drop, then a clean transfer.
    cycle(3'b100, 3'b000, '0, 1'b1, 1'b0);
    cycle(3'b100, 3'b000, '0, 1'b1, 1'b0);
    cycle(3'b000, 3'b000, '0, 1'b1, 1'b0);
    cycle(3'b100, 3'b100, '0, 1'b1, 1'b0);

    // Clear with errors set, then timeout on channel 0.
    cycle(3'b000, 3'b000, '0, 1'b1, 1'b1);
    for (int k = 0; k < TO + 2; k++) cycle(3'b001, 3'b000, '0, 1'b1, 1'b0);
    cycle(3'b001, 3'b001, '0, 1'b1, 1'b0);

    // Simultaneous drops on channels 1 and 2.
    cycle(3'b000, 3'b000, '0, 1'b1, 1'b1);
    cycle(3'b110, 3'b000, '0, 1'b1, 1'b0);
    cycle(3'b110, 3'b000, '0, 1'b1, 1'b0);
    cycle(3'b000, 3'b000, '0, 1'b1, 1'b0);

    // Counter saturation.
    cycle(3'b000, 3'b000, '0, 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) cycle(3'b001, 3'b001, '0, 1'b1, 1'b0);

    // Enable low mid-stall freezes stall length and suppresses the drop.
    cycle(3'b000, 3'b000, '0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) cycle(3'b001, 3'b000, '0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cycle(3'b000, 3'b000, '0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) cycle(3'b001, 3'b000, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a stall.
    cycle(3'b000, 3'b000, '0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) cycle(3'b001, 3'b000, '0, 1'b1, 1'b0);
    @(negedge CLK);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_now("async_reset");
    @(negedge CLK);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cycle(3'b001, 3'b000, '0, 1'b1, 1'b0);
    cycle(3'b001, 3'b001, '0, 1'b1, 1'b0);

    // Randomised traffic with alternating ready rates.
    for (int seg = 0; seg < 30; seg++) begin
      int div;
      div = (seg % 2 == 0) ? 1 : 19;
      for (int k = 0; k < 64; k++) rand_cycle(div);
    end

    @(posedge CLK);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
